// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: memory-op encoding, LSU FSM states, byte-enable masks
// and small op-classification helpers.
package riscv_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Codes 9..15 fall outside this range and behave as NONE.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word_op = (op == MEM_LW) || (op == MEM_SW);
        return (half_op && lo[0]) || (word_op && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU: store byte-enables and data replication on the
// request side, load byte/half extraction with sign or zero extension on the response side.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [3:0]  st_op,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [3:0]  ld_op,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = 32'd0;
        case (st_op)
            MEM_LB, MEM_LBU, MEM_SB: st_be = BE_BYTE << st_addr_lo;
            MEM_LH, MEM_LHU, MEM_SH: st_be = st_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            MEM_LW, MEM_SW:          st_be = BE_WORD;
            default:                 st_be = 4'b0000;
        endcase
        case (st_op)
            MEM_SB:  st_wdata = {4{st_data[7:0]}};
            MEM_SH:  st_wdata = {2{st_data[15:0]}};
            MEM_SW:  st_wdata = st_data;
            default: st_wdata = 32'd0;
        endcase
    end

    always_comb begin
        ld_byte = 8'sd0;
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

        ld_data = 32'd0;
        case (ld_op)
            MEM_LB:  ld_data = 32'(ld_byte);
            MEM_LH:  ld_data = 32'(ld_half);
            MEM_LW:  ld_data = ld_rdata;
            MEM_LBU: ld_data = {24'd0, ld_byte};
            MEM_LHU: ld_data = {16'd0, ld_half};
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: accepts one execute-stage op at a time, runs a single data-bus access
// with timeout, and returns a one-cycle writeback pulse (result, load data or exception).
module mem_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rd_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_data,
    output logic        exc_misaligned,
    output logic        exc_bus
);

    logic [0:0]  state;
    logic [7:0]  wait_cnt;
    logic [3:0]  op_p1;
    logic [1:0]  addr_lo_p1;
    logic [4:0]  rd_p1;
    logic        rd_we_p1;

    logic        accept;
    logic        wait_last;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign ex_ready  = (state == ST_IDLE);
    assign accept    = ex_valid && ex_ready;
    assign wait_last = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .st_op      (ex_mem_op),
        .st_addr_lo (ex_result[1:0]),
        .st_data    (ex_store_data),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_op      (op_p1),
        .ld_addr_lo (addr_lo_p1),
        .ld_rdata   (dmem_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            wait_cnt       <= 8'd0;
            op_p1          <= MEM_NONE;
            addr_lo_p1     <= 2'd0;
            rd_p1          <= 5'd0;
            rd_we_p1       <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'd0;
            dmem_be        <= 4'd0;
            dmem_wdata     <= 32'd0;
            wb_valid       <= 1'b0;
            wb_rd          <= 5'd0;
            wb_we          <= 1'b0;
            wb_data        <= 32'd0;
            exc_misaligned <= 1'b0;
            exc_bus        <= 1'b0;
        end else begin
            // Result flags are single-cycle pulses unless re-armed below.
            wb_valid       <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_bus        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!is_mem_op(ex_mem_op)) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= ex_rd;
                            wb_we    <= ex_rd_we && (ex_rd != 5'd0);
                            wb_data  <= ex_result;
                        end else if (is_misaligned(ex_mem_op, ex_result[1:0])) begin
                            wb_valid       <= 1'b1;
                            wb_rd          <= ex_rd;
                            wb_we          <= 1'b0;
                            wb_data        <= 32'd0;
                            exc_misaligned <= 1'b1;
                        end else begin
                            state      <= ST_WAIT;
                            wait_cnt   <= 8'd0;
                            op_p1      <= ex_mem_op;
                            addr_lo_p1 <= ex_result[1:0];
                            rd_p1      <= ex_rd;
                            rd_we_p1   <= ex_rd_we;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store(ex_mem_op);
                            dmem_addr  <= {ex_result[31:2], 2'b00};
                            dmem_be    <= st_be;
                            dmem_wdata <= st_wdata;
                        end
                    end
                end
                ST_WAIT: begin
                    // An ack in the terminal wait cycle still completes normally.
                    if (dmem_ack) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 8'd0;
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_p1;
                        wb_we    <= rd_we_p1 && (rd_p1 != 5'd0) && !is_store(op_p1);
                        wb_data  <= is_store(op_p1) ? 32'd0 : ld_data;
                    end else if (wait_last) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 8'd0;
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_p1;
                        wb_we    <= 1'b0;
                        wb_data  <= 32'd0;
                        exc_bus  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
